// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_pkg
//  Brief    : Shared types and width helpers for the sobel frame sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } frame_state_e;

    // Counter width for a counter whose values stay below 'bound'.
    function automatic int cnt_w(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_frame_ctrl_raster_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : raster_cnt
//  Brief    : Column/row raster position counter, wraps at end of frame.
//  Revision : 1.0 - initial release
// ============================================================================
module raster_cnt
    import sobel_pkg::*;
#(
    parameter int LINE_W_P  = 640,
    parameter int FRAME_H_P = 480
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          en_i,
    input  logic                          clr_i,
    output logic [cnt_w(LINE_W_P)-1:0]    col_o,
    output logic [cnt_w(FRAME_H_P)-1:0]   row_o,
    output logic                          last_o
);

    localparam int COL_W = cnt_w(LINE_W_P);
    localparam int ROW_W = cnt_w(FRAME_H_P);
    localparam logic [COL_W-1:0] c_col_last = COL_W'(LINE_W_P - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(FRAME_H_P - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (clr_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (en_i) begin
            if (r_col == c_col_last) begin
                r_col <= '0;
                r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign col_o  = r_col;
    assign row_o  = r_row;
    assign last_o = (r_col == c_col_last) && (r_row == c_row_last);

endmodule
`default_nettype wire

// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_frame_ctrl
//  Brief    : Frame sequencer around conv2d: flushes line buffers, drops
//             warm-up results and zeroes border results.
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH_P   = 8,
    parameter int LINE_W_P  = 640,
    parameter int FRAME_H_P = 480,
    parameter int FLUSH_N_P = LINE_W_P + 1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   pix_valid_i,
    output logic                   pix_ready_o,
    input  logic [WIDTH_P-1:0]     pix_data_i,
    output logic                   cv_valid_o,
    input  logic                   cv_ready_i,
    output logic [WIDTH_P-1:0]     cv_data_o,
    input  logic                   cr_valid_i,
    output logic                   cr_ready_o,
    input  logic [2*WIDTH_P-1:0]   cr_gx_i,
    input  logic [2*WIDTH_P-1:0]   cr_gy_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [2*WIDTH_P-1:0]   gx_o,
    output logic [2*WIDTH_P-1:0]   gy_o,
    output logic                   sof_o,
    output logic                   frame_done_o,
    output logic                   busy_o
);

    localparam int COL_W = cnt_w(LINE_W_P);
    localparam int ROW_W = cnt_w(FRAME_H_P);
    localparam int FL_W  = cnt_w(FLUSH_N_P + 1);
    localparam logic [FL_W-1:0]  c_fl_last  = FL_W'(FLUSH_N_P - 1);
    localparam logic [FL_W-1:0]  c_disc_n   = FL_W'(FLUSH_N_P);
    localparam logic [COL_W-1:0] c_col_last = COL_W'(LINE_W_P - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(FRAME_H_P - 1);

    frame_state_e     r_state;
    frame_state_e     w_state_nxt;
    logic [FL_W-1:0]  r_fl_cnt;
    logic [FL_W-1:0]  r_disc_cnt;
    logic             r_frame_done;

    logic [COL_W-1:0] w_in_col;
    logic [ROW_W-1:0] w_in_row;
    logic             w_in_last;
    logic             w_in_en;
    logic [COL_W-1:0] w_out_col;
    logic [ROW_W-1:0] w_out_row;
    logic             w_out_last;
    logic             w_out_hs;
    logic             w_out_last_hs;
    logic             w_discard;
    logic             w_border;
    logic             w_unused_in_pos;

    // Input position only advances on real image pixels, never on flush beats.
    assign w_in_en = pix_valid_i & cv_ready_i & ((r_state == IDLE) | (r_state == RUN));

    raster_cnt #(
        .LINE_W_P  (LINE_W_P),
        .FRAME_H_P (FRAME_H_P)
    ) u_in_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (w_in_en),
        .clr_i  (1'b0),
        .col_o  (w_in_col),
        .row_o  (w_in_row),
        .last_o (w_in_last)
    );

    raster_cnt #(
        .LINE_W_P  (LINE_W_P),
        .FRAME_H_P (FRAME_H_P)
    ) u_out_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (w_out_hs),
        .clr_i  (1'b0),
        .col_o  (w_out_col),
        .row_o  (w_out_row),
        .last_o (w_out_last)
    );

    assign w_unused_in_pos = ^{w_in_col, w_in_row};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        pix_ready_o = cv_ready_i;
        cv_valid_o  = pix_valid_i;
        cv_data_o   = pix_data_i;
        unique case (r_state)
            IDLE: begin
                if (pix_valid_i && cv_ready_i) w_state_nxt = RUN;
            end
            RUN: begin
                if (pix_valid_i && cv_ready_i && w_in_last) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                pix_ready_o = 1'b0;
                cv_valid_o  = 1'b1;
                cv_data_o   = '0;
                // A zero-latency conv2d could deliver the final result in the same cycle.
                if (cv_ready_i && (r_fl_cnt == c_fl_last))
                    w_state_nxt = w_out_last_hs ? IDLE : DRAIN;
            end
            DRAIN: begin
                pix_ready_o = 1'b0;
                cv_valid_o  = 1'b0;
                if (w_out_last_hs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_fl_cnt     <= '0;
            r_disc_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_out_last_hs;
            if ((r_state == FLUSH) && cv_ready_i)
                r_fl_cnt <= (r_fl_cnt == c_fl_last) ? '0 : r_fl_cnt + 1'b1;
            if (w_out_last_hs)
                r_disc_cnt <= '0;
            else if (w_discard && cr_valid_i)
                r_disc_cnt <= r_disc_cnt + 1'b1;
        end
    end

    // Warm-up results are windows over the previous flush/reset data.
    assign w_discard     = (r_disc_cnt != c_disc_n);
    assign valid_o       = cr_valid_i & ~w_discard;
    assign cr_ready_o    = w_discard | ready_i;
    assign w_out_hs      = valid_o & ready_i;
    assign w_out_last_hs = w_out_hs & w_out_last;

    assign w_border = (w_out_row == '0) || (w_out_row == c_row_last) ||
                      (w_out_col == '0) || (w_out_col == c_col_last);
    assign gx_o     = w_border ? '0 : cr_gx_i;
    assign gy_o     = w_border ? '0 : cr_gy_i;
    assign sof_o    = valid_o & (w_out_row == '0) & (w_out_col == '0);

    assign frame_done_o = r_frame_done;
    assign busy_o       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sobel_frame_ctrl
//  Brief    : Directed bench for sobel_frame_ctrl with a behavioural conv2d.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_frame_ctrl;

    localparam int WD   = 8;
    localparam int LW   = 4;
    localparam int FH   = 3;
    localparam int FN   = LW + 1;
    localparam int NPIX = LW * FH;

    logic            clk = 1'b0;
    logic            rstn_i = 1'b0;
    logic            pix_valid_i = 1'b0;
    logic            pix_ready_o;
    logic [WD-1:0]   pix_data_i = '0;
    logic            cv_valid_o;
    logic            cv_ready_i;
    logic [WD-1:0]   cv_data_o;
    logic            cr_valid_i;
    logic            cr_ready_o;
    logic [2*WD-1:0] cr_gx_i;
    logic [2*WD-1:0] cr_gy_i;
    logic            valid_o;
    logic            ready_i = 1'b1;
    logic [2*WD-1:0] gx_o;
    logic [2*WD-1:0] gy_o;
    logic            sof_o;
    logic            frame_done_o;
    logic            busy_o;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(
        .WIDTH_P   (WD),
        .LINE_W_P  (LW),
        .FRAME_H_P (FH),
        .FLUSH_N_P (FN)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .pix_valid_i  (pix_valid_i),
        .pix_ready_o  (pix_ready_o),
        .pix_data_i   (pix_data_i),
        .cv_valid_o   (cv_valid_o),
        .cv_ready_i   (cv_ready_i),
        .cv_data_o    (cv_data_o),
        .cr_valid_i   (cr_valid_i),
        .cr_ready_o   (cr_ready_o),
        .cr_gx_i      (cr_gx_i),
        .cr_gy_i      (cr_gy_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .gx_o         (gx_o),
        .gy_o         (gy_o),
        .sof_o        (sof_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o)
    );

    // ---------------- behavioural conv2d: output k = window centred on k-FN
    int              hist [1024];
    logic [2*WD-1:0] rb_gx [4];
    logic [2*WD-1:0] rb_gy [4];
    logic [1:0]      rb_wp, rb_rp;
    logic [2:0]      rb_cnt;
    int              n_in;

    function automatic int s(input int i);
        return (i < 0) ? 0 : hist[i];
    endfunction

    assign cv_ready_i = (rb_cnt < 3'd2);
    assign cr_valid_i = (rb_cnt != 3'd0);
    assign cr_gx_i    = rb_gx[rb_rp];
    assign cr_gy_i    = rb_gy[rb_rp];

    always @(posedge clk or negedge rstn_i) begin : conv_model
        int c, gx, gy;
        bit push, pop;
        if (!rstn_i) begin
            rb_wp  <= '0;
            rb_rp  <= '0;
            rb_cnt <= '0;
            n_in   <= 0;
        end else begin
            push = cv_valid_o && cv_ready_i;
            pop  = cr_valid_i && cr_ready_o;
            if (push) begin
                hist[n_in] = int'(cv_data_o);
                c  = n_in - FN;
                gx = (s(c-LW+1) - s(c-LW-1)) + 2*(s(c+1) - s(c-1)) + (s(c+LW+1) - s(c+LW-1));
                gy = (s(c+LW-1) + 2*s(c+LW) + s(c+LW+1)) - (s(c-LW-1) + 2*s(c-LW) + s(c-LW+1));
                rb_gx[rb_wp] <= 16'(gx);
                rb_gy[rb_wp] <= 16'(gy);
                rb_wp <= rb_wp + 2'd1;
                n_in  <= n_in + 1;
            end
            if (pop) rb_rp <= rb_rp + 2'd1;
            rb_cnt <= 3'(int'(rb_cnt) + int'(push) - int'(pop));
        end
    end

    // ---------------- monitor (monotonic counters, sampled mid-cycle)
    logic [2*WD-1:0] b_gx [256];
    logic [2*WD-1:0] b_gy [256];
    logic            b_sof [256];
    int nb = 0, fd_cnt = 0, n_cv = 0, n_cr = 0, n_fl = 0, n_flnz = 0;

    always @(negedge clk) begin
        if (valid_o && ready_i && nb < 256) begin
            b_gx[nb]  <= gx_o;
            b_gy[nb]  <= gy_o;
            b_sof[nb] <= sof_o;
            nb <= nb + 1;
        end
        if (frame_done_o) fd_cnt <= fd_cnt + 1;
        if (cv_valid_o && cv_ready_i) begin
            n_cv <= n_cv + 1;
            if (!pix_ready_o) begin
                n_fl <= n_fl + 1;
                if (cv_data_o != '0) n_flnz <= n_flnz + 1;
            end
        end
        if (cr_valid_i && cr_ready_o) n_cr <= n_cr + 1;
    end

    // ---------------- checking helpers
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: constant 100, mode 1: col*10
    task automatic send_frame(input int mode, input bit rnd, input int npix, output int fd_at_first);
        fd_at_first = -1;
        for (int i = 0; i < npix; i++) begin
            int  tmo;
            bit  hs;
            tmo = 0;
            hs  = 1'b0;
            pix_data_i = (mode == 0) ? 8'd100 : 8'(10 * (i % LW));
            do begin
                pix_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                hs = pix_valid_i && pix_ready_o;
                @(posedge clk);
                #1;
                if (hs && i == 0) fd_at_first = fd_cnt;
                tmo++;
            end while (!hs && tmo < 300);
            if (!hs) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        pix_valid_i = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (fd_cnt < target && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("frame_done_timeout", 32'(fd_cnt >= target), 32'd1);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_image(input string tag, input int base, input int mode);
        for (int k = 0; k < NPIX; k++) begin
            logic [31:0] egx;
            egx = (mode == 1 && (k == 5 || k == 6)) ? 32'd80 : 32'd0;
            chk({tag, "_gx"}, 32'(b_gx[base+k]), egx);
            chk({tag, "_gy"}, 32'(b_gy[base+k]), 32'd0);
            chk({tag, "_sof"}, 32'(b_sof[base+k]), 32'(k == 0));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence
    initial begin : stim
        int b_nb, b_fd, b_cv, b_cr, b_fl, b_nz, fd_first;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_cv_valid_o", 32'(cv_valid_o), 32'd0);
        chk("rst_busy_o", 32'(busy_o), 32'd0);
        chk("rst_frame_done_o", 32'(frame_done_o), 32'd0);
        chk("rst_sof_o", 32'(sof_o), 32'd0);
        chk("rst_pix_ready_o", 32'(pix_ready_o), 32'd1);
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // scenario 1: constant image
        b_nb = nb; b_fd = fd_cnt; b_cv = n_cv; b_cr = n_cr; b_fl = n_fl; b_nz = n_flnz;
        send_frame(0, 1'b0, NPIX, fd_first);
        chk("s1_flush_pix_ready", 32'(pix_ready_o), 32'd0);
        chk("s1_flush_busy", 32'(busy_o), 32'd1);
        wait_frames(b_fd + 1);
        chk("s1_beats", 32'(nb - b_nb), 32'(NPIX));
        chk("s1_frame_done", 32'(fd_cnt - b_fd), 32'd1);
        chk("s1_flush_beats", 32'(n_fl - b_fl), 32'(FN));
        chk("s1_flush_nonzero", 32'(n_flnz - b_nz), 32'd0);
        chk("s1_cv_hs", 32'(n_cv - b_cv), 32'(NPIX + FN));
        chk("s1_cr_hs", 32'(n_cr - b_cr), 32'(NPIX + FN));
        chk("s1_busy_idle", 32'(busy_o), 32'd0);
        check_image("s1", b_nb, 0);

        // scenario 2: horizontal ramp
        b_nb = nb; b_fd = fd_cnt;
        send_frame(1, 1'b0, NPIX, fd_first);
        wait_frames(b_fd + 1);
        chk("s2_beats", 32'(nb - b_nb), 32'(NPIX));
        chk("s2_frame_done", 32'(fd_cnt - b_fd), 32'd1);
        check_image("s2", b_nb, 1);

        // scenario 3: ramp with random valid and toggling ready
        b_nb = nb; b_fd = fd_cnt;
        fork
            send_frame(1, 1'b1, NPIX, fd_first);
            begin
                int t;
                t = 0;
                while (fd_cnt < b_fd + 1 && t < 1000) begin
                    @(posedge clk);
                    #1;
                    ready_i = ~ready_i;
                    t++;
                end
                ready_i = 1'b1;
            end
        join
        wait_frames(b_fd + 1);
        chk("s3_beats", 32'(nb - b_nb), 32'(NPIX));
        chk("s3_frame_done", 32'(fd_cnt - b_fd), 32'd1);
        check_image("s3", b_nb, 1);

        // scenario 4: back-to-back frames, second presented during flush
        b_nb = nb; b_fd = fd_cnt;
        send_frame(0, 1'b0, NPIX, fd_first);
        chk("s4_stall_in_flush", 32'(pix_ready_o), 32'd0);
        send_frame(1, 1'b0, NPIX, fd_first);
        chk("s4_second_after_done", 32'(fd_first), 32'(b_fd + 1));
        wait_frames(b_fd + 2);
        chk("s4_beats", 32'(nb - b_nb), 32'(2 * NPIX));
        chk("s4_frame_done", 32'(fd_cnt - b_fd), 32'd2);
        check_image("s4f1", b_nb, 0);
        check_image("s4f2", b_nb + NPIX, 1);

        // scenario 5: reset after 7 pixels, then a clean frame
        send_frame(1, 1'b0, 7, fd_first);
        rstn_i = 1'b0;
        @(negedge clk);
        chk("s5_rst_valid_o", 32'(valid_o), 32'd0);
        chk("s5_rst_busy_o", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b_nb = nb; b_fd = fd_cnt;
        send_frame(1, 1'b0, NPIX, fd_first);
        wait_frames(b_fd + 1);
        chk("s5_beats", 32'(nb - b_nb), 32'(NPIX));
        chk("s5_frame_done", 32'(fd_cnt - b_fd), 32'd1);
        check_image("s5", b_nb, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
